// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Optional three-attempt retry on failure: define PS2_HOST_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 5000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000,
  parameter int TIMER_W              = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  output logic       cmd_busy,
  output logic       cmd_done,
  output logic       cmd_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_WAIT_IDLE,
    S_FAIL
  } state_t;

  // Timer compare values are "last cycle" counts: the timer starts at 0 on entry.
  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST    = TIMER_W'(XFER_TIMEOUT_CYCLES - 1);

  state_t             state, state_nx;
  logic [TIMER_W-1:0] timer, timer_nx, timer_inc;
  logic [3:0]         edge_cnt, edge_cnt_nx;
  logic [7:0]         data_q, data_nx;
  logic [1:0]         clk_sync, dat_sync;
  logic               clk_prev;
  logic               clk_s, dat_s, clk_fall;
  logic [10:0]        frame;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]         retry_cnt, retry_nx;
`endif

  // Bring the open-drain pad values into CLOCK_50 and remember the last synced clock
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s    = clk_sync[1];
  assign dat_s    = dat_sync[1];
  assign clk_fall = clk_prev & ~clk_s;

  // Frame bit k is what the line carries after falling edge k (k = 0 is the start bit)
  assign frame     = {1'b1, ~^data_q, data_q, 1'b0};
  assign timer_inc = (timer == {TIMER_W{1'b1}}) ? timer : timer + 1'b1;

  // FSM state, cycle timer, edge counter and latched byte
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      edge_cnt  <= 4'd0;
      data_q    <= 8'd0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_cnt <= 2'd0;
`endif
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      edge_cnt  <= edge_cnt_nx;
      data_q    <= data_nx;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_cnt <= retry_nx;
`endif
    end
  end

  // Next-state, line drive and handshake outputs, all decoded from registered state
  always_comb begin
    state_nx    = state;
    timer_nx    = timer_inc;
    edge_cnt_nx = edge_cnt;
    data_nx     = data_q;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_nx    = retry_cnt;
`endif
    ps2_clk_oe  = 1'b0;
    ps2_dat_oe  = 1'b0;
    cmd_done    = 1'b0;
    cmd_error   = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nx = '0;
        if (cmd_send) begin
          data_nx     = cmd_data;
          edge_cnt_nx = 4'd0;
          state_nx    = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_nx    = 2'd0;
`endif
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (timer == INHIBIT_LAST) begin
          timer_nx = '0;
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        ps2_dat_oe = ~frame[edge_cnt];
        if (clk_fall) begin
          edge_cnt_nx = 4'd1;
          timer_nx    = '0;
          state_nx    = S_SEND;
        end else if (timer == START_LAST) begin
          state_nx = S_FAIL;
        end
      end
      S_SEND: begin
        ps2_dat_oe = ~frame[edge_cnt];
        // The eleventh falling edge carries the device ACK; it wins over a same-cycle timeout
        if (clk_fall && edge_cnt == 4'd10) begin
          state_nx = dat_s ? S_FAIL : S_WAIT_IDLE;
        end else if (timer == XFER_LAST) begin
          state_nx = S_FAIL;
        end else if (clk_fall) begin
          edge_cnt_nx = edge_cnt + 4'd1;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          cmd_done = 1'b1;
          state_nx = S_IDLE;
        end else if (timer == XFER_LAST) begin
          state_nx = S_FAIL;
        end
      end
      S_FAIL: begin
`ifdef PS2_HOST_TX_RETRY_EN
        if (retry_cnt != 2'd2) begin
          retry_nx    = retry_cnt + 2'd1;
          timer_nx    = '0;
          edge_cnt_nx = 4'd0;
          state_nx    = S_INHIBIT;
        end else begin
          cmd_error = 1'b1;
          state_nx  = S_IDLE;
        end
`else
        cmd_error = 1'b1;
        state_nx  = S_IDLE;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
    cmd_busy = (state != S_IDLE) && !cmd_done && !cmd_error;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable scanning) or 0xFF (reset).
- It is the outbound counterpart of the existing PS/2 receive path.
- It sits beside the PS2 receive controller in the top level and shares the PS2_CLK and PS2_DAT open-drain lines with it.
- The top level builds the tristates: PS2_CLK = ps2_clk_oe ? 0 : Z, and likewise for PS2_DAT. The raw pad values feed ps2_clk_in and ps2_dat_in.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit time before the request (100 us at 50 MHz).
- START_TIMEOUT_CYCLES, 750000: maximum wait for the device's first clock falling edge after the request (15 ms).
- XFER_TIMEOUT_CYCLES, 100000: maximum time from the first falling edge to the ACK (2 ms).
- TIMER_W, 20: timer width. It must hold the largest cycle count above.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_data  in  8  byte to send. Sampled on an accepted cmd_send.
- cmd_send  in  1  one-cycle request strobe.
- cmd_busy  out  1  high from acceptance until done or error.
- cmd_done  out  1  one-cycle pulse on an ACKed transfer.
- cmd_error  out  1  one-cycle pulse on a timeout or missing ACK.
- ps2_clk_in  in  1  raw PS2_CLK pad value (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pad value (asynchronous).
- ps2_clk_oe  out  1  1 pulls PS2_CLK low.
- ps2_dat_oe  out  1  1 pulls PS2_DAT low.

Behaviour:
- Clock and reset: one clock domain, CLOCK_50; reset is asynchronous and active-high.
- Reset values: all outputs are 0 while reset is high, which means both lines are released. Reset asserted mid-transfer releases both lines immediately (no clock edge needed) and returns the FSM to IDLE.
- Input sync: ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer, reset value 1.
- Falling-edge detect: clk_fall = (previous synced clk == 1) and (current synced clk == 0).
- Parity: odd, computed over the 8 data bits (~^cmd_data).
- Handshake rules:
  - cmd_send is accepted only in IDLE. It is ignored while cmd_busy = 1, with no queueing.
  - cmd_busy rises on the cycle after acceptance.
  - cmd_done and cmd_error are mutually exclusive. cmd_busy falls in the same cycle as either pulse.
- FSM states:
  - IDLE: no line is driven.
    - On cmd_send: latch cmd_data, clear the timer, go to INHIBIT.
  - INHIBIT: ps2_clk_oe = 1, ps2_dat_oe = 0. Stay exactly INHIBIT_CYCLES cycles.
    - Then set ps2_dat_oe = 1 (start bit) and go to REQ.
  - REQ: ps2_dat_oe = 1, ps2_clk_oe = 0 (clock released). Clear the timer.
    - On clk_fall: drive data bit 0 (ps2_dat_oe = ~bit), set edge count = 1, go to SEND.
    - If the timer reaches START_TIMEOUT_CYCLES: go to FAIL.
  - SEND: on each clk_fall, edge count increments. The host changes data only after a falling edge.
    - Edges 2–8: drive bits 1–7.
    - Edge 9: drive parity.
    - Edge 10: release data (stop bit = 1).
    - Edge 11: sample synced data. 0 means ACK, go to WAIT_IDLE. 1 means no ACK, go to FAIL.
    - The timer runs from entry to SEND. If it reaches XFER_TIMEOUT_CYCLES before edge 11: go to FAIL.
  - WAIT_IDLE: no line is driven. Wait until synced clk and data are both 1.
    - Then pulse cmd_done and go to IDLE.
    - The XFER timer keeps running. Expiry goes to FAIL.
  - FAIL: release both lines, pulse cmd_error for one cycle, go to IDLE.
- Boundary conditions:
  - A clk_fall during INHIBIT is ignored.
  - Edge count is 4 bits and never exceeds 11.
  - The timer saturates and does not wrap.
- Latency: cmd_send to first pin activity (ps2_clk_oe = 1) is 1 cycle.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- When defined:
  - FAIL does not report immediately. It re-enters INHIBIT with the same latched byte, up to 2 retries (3 attempts total).
  - cmd_error pulses only after the third failure.
  - cmd_busy stays high throughout the retries.
  - A 2-bit retry counter clears on acceptance.
- When undefined: the first failure pulses cmd_error, with no retry logic synthesized.

Test Plan:
1. Byte 0xED, odd parity. Set INHIBIT_CYCLES = 20. Pulse cmd_send. The bench device model clocks at a 40-cycle period and ACKs.
   - ps2_clk_oe is high for exactly 20 cycles.
   - Data observed on the device's rising edges: 0, 1,0,1,1,0,1,1,1, 1 (parity), 1 (stop).
   - cmd_done pulses once. cmd_busy falls with it.
2. Byte 0xF4.
   - Bits observed: 0,0,1,0,1,1,1,1.
   - Parity = 0.
   - cmd_done pulses.
3. No device clock. Set START_TIMEOUT_CYCLES = 100.
   - cmd_error pulses exactly 100 cycles after REQ entry.
   - Both oe outputs are 0, and cmd_done never pulses.
4. Device holds data high at edge 11.
   - cmd_error pulses and the lines are released.
   - With PS2_HOST_TX_RETRY_EN defined: 3 INHIBIT phases are observed before cmd_error.
5. cmd_send pulsed again at edge 5 of an active transfer.
   - It is ignored: the transmitted byte is unchanged and only one cmd_done occurs.
6. Assert reset at edge 6.
   - ps2_clk_oe and ps2_dat_oe are 0 before the next CLOCK_50 edge, and cmd_busy = 0.
   - After reset is released, a new cmd_send of 0xFF completes with parity = 1.
